// File: rtl/vend_pkg.sv
// Shared vending definitions: coin unit values, hopper select codes, dispenser FSM states.
// Consumed by change_dispenser, change_sel and change_dispenser_if.
package vend_pkg;

    // All money values are in 0.5-yuan units, matching coin_count's coin_val.
    localparam int TEN_VAL  = 20;
    localparam int ONE_VAL  = 2;
    localparam int HALF_VAL = 1;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        SEL_NONE = 2'b00,
        SEL_TEN  = 2'b01,
        SEL_ONE  = 2'b10,
        SEL_HALF = 2'b11
    } sel_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SELECT  = 3'd1,
        ST_REQ     = 3'd2,
        ST_RELEASE = 3'd3,
        ST_DONE    = 3'd4,
        ST_FAULT   = 3'd5
    } state_t;

    function automatic int unsigned sel_value(input sel_t sel);
        case (sel)
            SEL_TEN:  return TEN_VAL;
            SEL_ONE:  return ONE_VAL;
            SEL_HALF: return HALF_VAL;
            default:  return 0;
        endcase
    endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Bus between the vending top / coin hoppers and change_dispenser.
// master = vending top and hopper side, slave = change_dispenser.
interface change_dispenser_if
    import vend_pkg::*;
#(
    parameter int WIDTH = 10
);
    // Hopper handshake is four-phase: the dispenser raises disp_req with disp_sel
    // stable; the hopper ejects one coin and raises disp_ack; the dispenser drops
    // disp_req; the hopper drops disp_ack; only then may the next request start.
    logic             start;
    logic [WIDTH-1:0] amount;
    logic             empty_ten;
    logic             empty_one;
    logic             empty_half;
    logic             disp_ack;
    logic             fault_clr;

    logic             disp_req;
    sel_t             disp_sel;
    logic             busy;
    logic             done;
    logic             fault;
    logic [WIDTH-1:0] remaining;
    logic [CNT_W-1:0] cnt_ten;
    logic [CNT_W-1:0] cnt_one;
    logic [CNT_W-1:0] cnt_half;
    state_t           dbg_state;

    modport master (
        output start, amount, empty_ten, empty_one, empty_half, disp_ack, fault_clr,
        input  disp_req, disp_sel, busy, done, fault, remaining,
               cnt_ten, cnt_one, cnt_half, dbg_state
    );

    modport slave (
        input  start, amount, empty_ten, empty_one, empty_half, disp_ack, fault_clr,
        output disp_req, disp_sel, busy, done, fault, remaining,
               cnt_ten, cnt_one, cnt_half, dbg_state
    );

endinterface

// File: rtl/change_sel.sv
// Greedy coin picker: largest non-empty denomination whose value fits in remaining.
// Purely combinational; none_ok is high when nothing can be paid.
module change_sel
    import vend_pkg::*;
#(
    parameter int WIDTH = 10
) (
    input  logic [WIDTH-1:0] remaining,
    input  logic             empty_ten,
    input  logic             empty_one,
    input  logic             empty_half,
    output sel_t             sel,
    output logic             none_ok
);

    always_comb begin
        sel = SEL_NONE;
        if (!empty_ten && (remaining >= WIDTH'(TEN_VAL))) begin
            sel = SEL_TEN;
        end else if (!empty_one && (remaining >= WIDTH'(ONE_VAL))) begin
            sel = SEL_ONE;
        end else if (!empty_half && (remaining >= WIDTH'(HALF_VAL))) begin
            sel = SEL_HALF;
        end
    end

    assign none_ok = (sel == SEL_NONE);

endmodule

// File: rtl/change_dispenser.sv
// Pays out a balance as coins via a four-phase req/ack hopper handshake.
// Optional ack watchdog enabled by defining CHG_TIMEOUT_EN.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int WIDTH      = 10,
    parameter int MAX_AMOUNT = 1000
`ifdef CHG_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 1000000
`endif
) (
    input  logic               clk,
    input  logic               reset,
    change_dispenser_if.slave  bus
);

    state_t           state;
    state_t           state_nxt;
    sel_t             sel_q;
    sel_t             pick;
    logic             none_ok;
    logic [WIDTH-1:0] remaining_q;
    logic [WIDTH-1:0] amount_clamped;
    logic [WIDTH-1:0] coin_val;
    logic [CNT_W-1:0] cnt_ten_q;
    logic [CNT_W-1:0] cnt_one_q;
    logic [CNT_W-1:0] cnt_half_q;
    logic             timeout_hit;

    logic             req_o;
    sel_t             sel_o;
    logic             busy_o;
    logic             done_o;
    logic             fault_o;

    change_sel #(
        .WIDTH (WIDTH)
    ) u_sel (
        .remaining  (remaining_q),
        .empty_ten  (bus.empty_ten),
        .empty_one  (bus.empty_one),
        .empty_half (bus.empty_half),
        .sel        (pick),
        .none_ok    (none_ok)
    );

    assign amount_clamped = (bus.amount > WIDTH'(MAX_AMOUNT)) ? WIDTH'(MAX_AMOUNT) : bus.amount;
    assign coin_val       = WIDTH'(sel_value(sel_q));

`ifdef CHG_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;

    // Counts REQ cycles without ack; the cycle holding TIMEOUT_CYCLES-1 is the last one in REQ.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_cnt <= '0;
        end else if ((state == ST_REQ) && !bus.disp_ack) begin
            wd_cnt <= wd_cnt + 1'b1;
        end else begin
            wd_cnt <= '0;
        end
    end

    assign timeout_hit = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (bus.start) state_nxt = ST_SELECT;
            end
            ST_SELECT: begin
                if (remaining_q == '0) begin
                    state_nxt = ST_DONE;
                end else if (none_ok) begin
                    state_nxt = ST_FAULT;
                end else begin
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (bus.disp_ack) begin
                    state_nxt = ST_RELEASE;
                end else if (timeout_hit) begin
                    state_nxt = ST_FAULT;
                end
            end
            ST_RELEASE: begin
                if (!bus.disp_ack) state_nxt = ST_SELECT;
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            ST_FAULT: begin
                if (bus.fault_clr) state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Outputs are decoded from state alone so an async reset drops disp_req immediately.
    always_comb begin
        req_o   = 1'b0;
        sel_o   = SEL_NONE;
        busy_o  = (state != ST_IDLE);
        done_o  = 1'b0;
        fault_o = 1'b0;
        case (state)
            ST_REQ: begin
                req_o = 1'b1;
                sel_o = sel_q;
            end
            ST_RELEASE: begin
                sel_o = sel_q;
            end
            ST_DONE: begin
                done_o = 1'b1;
            end
            ST_FAULT: begin
                fault_o = 1'b1;
            end
            default: begin
                req_o = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            remaining_q <= '0;
            sel_q       <= SEL_NONE;
            cnt_ten_q   <= '0;
            cnt_one_q   <= '0;
            cnt_half_q  <= '0;
        end else begin
            if ((state == ST_IDLE) && bus.start) begin
                remaining_q <= amount_clamped;
                cnt_ten_q   <= '0;
                cnt_one_q   <= '0;
                cnt_half_q  <= '0;
            end
            // Empty flags only matter here; the choice is frozen for the whole REQ phase.
            if ((state == ST_SELECT) && (remaining_q != '0) && !none_ok) begin
                sel_q <= pick;
            end
            if ((state == ST_REQ) && bus.disp_ack) begin
                remaining_q <= remaining_q - coin_val;
                case (sel_q)
                    SEL_TEN:  if (cnt_ten_q  != '1) cnt_ten_q  <= cnt_ten_q  + 1'b1;
                    SEL_ONE:  if (cnt_one_q  != '1) cnt_one_q  <= cnt_one_q  + 1'b1;
                    SEL_HALF: if (cnt_half_q != '1) cnt_half_q <= cnt_half_q + 1'b1;
                    default:  ;
                endcase
            end
        end
    end

    assign bus.disp_req  = req_o;
    assign bus.disp_sel  = sel_o;
    assign bus.busy      = busy_o;
    assign bus.done      = done_o;
    assign bus.fault     = fault_o;
    assign bus.remaining = remaining_q;
    assign bus.cnt_ten   = cnt_ten_q;
    assign bus.cnt_one   = cnt_one_q;
    assign bus.cnt_half  = cnt_half_q;
    assign bus.dbg_state = state;

endmodule
